// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Sequences the control-flow redirect that follows a taken branch or jump
// resolved in EX. The target is latched and offered to the fetch unit over a
// valid/ready handshake. While the redirect is outstanding, and for
// FLUSH_CYCLES afterwards while stale fetch responses drain, IF/ID are
// flushed and EX is stalled. A trap/exception kill aborts any sequence.
// A misaligned target raises a one-cycle exception pulse instead.
//
// Parameters:
//   XLEN         PC / target width
//   FLUSH_CYCLES post-handshake drain cycles (0 allowed)
//   CNT_W        width of the completed-redirect counter
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   ex_valid     EX holds a valid instruction
//   ex_pc_sel    taken branch / jump in EX
//   ex_target    redirect target PC
//   kill         trap redirect; overrides everything
//   fetch_ready  fetch unit accepts the redirect
//   redir_valid  redirect request to fetch
//   redir_pc     redirect PC, stable while redir_valid
//   flush_if     squash IF stage / fetch responses
//   flush_id     squash ID stage
//   stall_ex     freeze EX
//   exc_misalign one-cycle pulse on a misaligned branch target
//   redir_count  completed redirects, wraps
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_pc_sel,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             kill,
  input  logic             fetch_ready,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             stall_ex,
  output logic             exc_misalign,
  output logic [CNT_W-1:0] redir_count
);

  // Drain counter is sized to hold FLUSH_CYCLES; keep at least one bit so the
  // FLUSH_CYCLES==0 build still elaborates (the counter is then never used).
  localparam int            DW         = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          det;

  // Bit 0 of the target never reaches the latch (forced to 0) and plays no
  // part in the alignment check.
  logic          unused_tgt_bit0;
  assign unused_tgt_bit0 = ex_target[0];

  assign det = ex_valid & ex_pc_sel;

  // Handshake outputs are pure state decodes: no input-to-output path.
  assign redir_valid = (state == WAIT_ACK);
  assign flush_if    = (state != IDLE);
  assign flush_id    = (state != IDLE);
  assign stall_ex    = (state != IDLE);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      redir_pc     <= '0;
      exc_misalign <= 1'b0;
      redir_count  <= '0;
    end else begin
      // Pulse output: low unless explicitly raised this cycle.
      exc_misalign <= 1'b0;

      if (kill) begin
        // Trap redirect wins over detect, handshake and drain alike; the
        // counter is left untouched even if fetch accepted this cycle.
        state     <= IDLE;
        drain_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (det) begin
              if (ex_target[1]) begin
                exc_misalign <= 1'b1;
              end else begin
                redir_pc <= {ex_target[XLEN-1:1], 1'b0};
                state    <= WAIT_ACK;
              end
            end
          end

          WAIT_ACK: begin
            // redir_valid is implied by this state, so fetch_ready alone
            // completes the handshake. redir_pc is only written in IDLE,
            // which keeps it stable while the request is up.
            if (fetch_ready) begin
              redir_count <= redir_count + CNT_W'(1);
              if (FLUSH_CYCLES == 0) begin
                state <= IDLE;
              end else begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_INIT;
              end
            end
          end

          DRAIN: begin
            drain_cnt <= drain_cnt - DW'(1);
            if (drain_cnt <= DW'(1)) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Drives two instances from shared stimulus: one with default parameters
// (FLUSH_CYCLES=2, CNT_W=32) and one with FLUSH_CYCLES=0, CNT_W=4 for the
// zero-drain / counter-wrap behaviour. Each instance is compared every cycle
// against a transaction-level reference model, plus a few directed checks.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_pc_sel;
  logic [31:0] ex_target;
  logic        kill;
  logic        fetch_ready;

  logic        a_valid, a_flush_if, a_flush_id, a_stall, a_mis;
  logic [31:0] a_pc;
  logic [31:0] a_cnt;
  logic        b_valid, b_flush_if, b_flush_id, b_stall, b_mis;
  logic [31:0] b_pc;
  logic [3:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc_sel(ex_pc_sel),
    .ex_target(ex_target), .kill(kill), .fetch_ready(fetch_ready),
    .redir_valid(a_valid), .redir_pc(a_pc), .flush_if(a_flush_if),
    .flush_id(a_flush_id), .stall_ex(a_stall), .exc_misalign(a_mis),
    .redir_count(a_cnt)
  );

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc_sel(ex_pc_sel),
    .ex_target(ex_target), .kill(kill), .fetch_ready(fetch_ready),
    .redir_valid(b_valid), .redir_pc(b_pc), .flush_if(b_flush_if),
    .flush_id(b_flush_id), .stall_ex(b_stall), .exc_misalign(b_mis),
    .redir_count(b_cnt)
  );

  // Reference model: a redirect is either pending at fetch, or some number
  // of drain cycles remain; the sequence is busy while either holds.
  int          drain_len [2] = '{2, 0};
  longint      cnt_mod   [2] = '{64'h1_0000_0000, 16};
  bit          m_pending [2];
  int          m_drain   [2];
  longint      m_count   [2];
  logic [31:0] m_pc      [2];
  bit          m_mis     [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit busy;
      busy = m_pending[i] || (m_drain[i] > 0);
      m_mis[i] = 1'b0;
      if (reset) begin
        m_pending[i] = 1'b0;
        m_drain[i]   = 0;
        m_count[i]   = 0;
        m_pc[i]      = '0;
      end else if (kill) begin
        m_pending[i] = 1'b0;
        m_drain[i]   = 0;
      end else if (!busy) begin
        if (ex_valid && ex_pc_sel) begin
          if (ex_target[1]) begin
            m_mis[i] = 1'b1;
          end else begin
            m_pc[i]      = ex_target & 32'hFFFF_FFFE;
            m_pending[i] = 1'b1;
          end
        end
      end else if (m_pending[i]) begin
        if (fetch_ready) begin
          m_pending[i] = 1'b0;
          m_count[i]   = (m_count[i] + 1) % cnt_mod[i];
          m_drain[i]   = drain_len[i];
        end
      end else begin
        m_drain[i]--;
      end
    end
  endtask

  task automatic compare_all();
    bit busy_a, busy_b;
    busy_a = m_pending[0] || (m_drain[0] > 0);
    busy_b = m_pending[1] || (m_drain[1] > 0);
    check("a_valid",    32'(a_valid),    32'(m_pending[0]));
    check("a_pc",       a_pc,            m_pc[0]);
    check("a_flush_if", 32'(a_flush_if), 32'(busy_a));
    check("a_flush_id", 32'(a_flush_id), 32'(busy_a));
    check("a_stall",    32'(a_stall),    32'(busy_a));
    check("a_mis",      32'(a_mis),      32'(m_mis[0]));
    check("a_count",    a_cnt,           32'(m_count[0]));
    check("b_valid",    32'(b_valid),    32'(m_pending[1]));
    check("b_pc",       b_pc,            m_pc[1]);
    check("b_stall",    32'(b_stall),    32'(busy_b));
    check("b_flush",    32'({b_flush_if, b_flush_id}), 32'({busy_b, busy_b}));
    check("b_mis",      32'(b_mis),      32'(m_mis[1]));
    check("b_count",    32'(b_cnt),      32'(m_count[1]));
  endtask

  // One clock: model consumes the inputs held across the edge, then the
  // outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input bit sel, input logic [31:0] tgt,
                       input bit fr, input bit k, input bit rst);
    ex_valid    = v;
    ex_pc_sel   = sel;
    ex_target   = tgt;
    fetch_ready = fr;
    kill        = k;
    reset       = rst;
  endtask

  initial begin
    drive(0, 0, '0, 0, 0, 1);
    step();
    step();
    // Reset state, explicit.
    check("rst_a_pc", a_pc, 32'h0);
    check("rst_a_cnt", a_cnt, 32'h0);
    check("rst_a_valid", 32'(a_valid), 32'h0);

    // Immediate ack, 0x1000.
    drive(1, 1, 32'h0000_1000, 1, 0, 0);
    step();
    check("imm_pc", a_pc, 32'h0000_1000);
    check("imm_valid", 32'(a_valid), 32'h1);
    drive(0, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step();
    check("imm_cnt", a_cnt, 32'h1);
    check("imm_stall_done", 32'(a_stall), 32'h0);

    // Backpressure with ex_target changing underneath.
    drive(1, 1, 32'h0000_1000, 0, 0, 0);
    step();
    drive(1, 1, 32'h0000_2000, 0, 0, 0);
    step();
    step();
    drive(1, 1, 32'h0000_2000, 1, 0, 0);
    step();
    check("bp_pc_held", a_pc, 32'h0000_1000);
    drive(0, 0, 32'h0000_2000, 1, 0, 0);
    for (int i = 0; i < 4; i++) step();
    check("bp_cnt", a_cnt, 32'h2);

    // Misaligned target.
    drive(1, 1, 32'h0000_1002, 1, 0, 0);
    step();
    check("mis_pulse", 32'(a_mis), 32'h1);
    drive(0, 0, 32'h0, 1, 0, 0);
    step();
    check("mis_gone", 32'(a_mis), 32'h0);

    // Kill in WAIT_ACK coincident with fetch_ready, then kill with det.
    drive(1, 1, 32'h0000_3000, 0, 0, 0);
    step();
    drive(0, 0, 32'h0, 1, 1, 0);
    step();
    check("kill_cnt", a_cnt, 32'h2);
    check("kill_stall", 32'(a_stall), 32'h0);
    drive(1, 1, 32'h0000_4000, 1, 1, 0);
    step();
    check("kill_det_valid", 32'(a_valid), 32'h0);
    check("kill_det_pc", a_pc, 32'h0000_3000);

    // Reset mid-DRAIN, then a normal redirect.
    drive(1, 1, 32'h0000_5000, 1, 0, 0);
    step();
    drive(0, 0, 32'h0, 1, 0, 0);
    step();
    drive(0, 0, 32'h0, 1, 0, 1);
    step();
    check("rstd_pc", a_pc, 32'h0);
    check("rstd_cnt", a_cnt, 32'h0);
    drive(1, 1, 32'h0000_6000, 1, 0, 0);
    step();
    check("rstd_redir", a_pc, 32'h0000_6000);
    drive(0, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step();

    // Zero drain / wrap: 16 back-to-back redirects on the CNT_W=4 instance.
    drive(0, 0, 32'h0, 0, 0, 1);
    step();
    drive(1, 1, 32'h0000_0100, 1, 0, 0);
    for (int i = 0; i < 32; i++) begin
      ex_target = 32'h0000_0100 + 32'(i) * 4;
      step();
    end
    check("wrap_b_cnt", 32'(b_cnt), 32'h0);
    drive(0, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
